// File: rtl/coa_pkg.sv
// Shared sizing and types for the register-file read side.
package coa_pkg;
  localparam int DATA_W = 8;
  localparam int NREG   = 4;
  localparam int AW     = $clog2(NREG);
  // Number of scoreboard query ports: rs1, rs2, dst.
  localparam int NQ     = 3;

  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode, execute and writeback signals seen by operand_fetch.
interface operand_fetch_if;
  import coa_pkg::*;

  logic      id_valid;
  logic      id_ready;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      id_use_rs2;
  reg_addr_t id_dst;
  logic      id_dst_en;

  logic      op_valid;
  logic      op_ready;
  data_t     op_a;
  data_t     op_b;
  reg_addr_t op_dst;
  logic      op_dst_en;

  logic      wb_valid;
  reg_addr_t wb_addr;
  data_t     wb_data;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs2, id_dst, id_dst_en,
    input  op_ready, wb_valid, wb_addr, wb_data,
    output id_ready, op_valid, op_a, op_b, op_dst, op_dst_en
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs2, id_dst, id_dst_en,
    output op_ready, wb_valid, wb_addr, wb_data,
    input  id_ready, op_valid, op_a, op_b, op_dst, op_dst_en
  );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits with set-over-clear priority and blocked() queries.
module reg_scoreboard
  import coa_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  reg_addr_t       set_addr,
  input  logic            clr_en,
  input  reg_addr_t       clr_addr,
  input  reg_addr_t       q_addr [NQ],
  output logic [NQ-1:0]   q_blocked,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      // An issue claiming the register in the same cycle its writer retires keeps it busy.
      assign busy_d[gi] = (set_en && set_addr == reg_addr_t'(gi)) ? 1'b1 :
                          (clr_en && clr_addr == reg_addr_t'(gi)) ? 1'b0 :
                          busy_q[gi];
    end

    for (genvar gi = 0; gi < NQ; gi++) begin : g_query
      assign q_blocked[gi] = busy_q[q_addr[gi]] && !(clr_en && clr_addr == q_addr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: rtl/operand_fetch.sv
// Register file read side: hazard stall, writeback bypass and a one-deep operand register.
module operand_fetch
  import coa_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  operand_fetch_if.slave  bus,
  output logic [NREG-1:0] busy,
  output logic            wb_spurious
);
  data_t     regs_q [NREG];
  data_t     regs_d [NREG];
  reg_addr_t q_addr [NQ];
  logic [NQ-1:0] blk;
  logic      hazard, accept;
  data_t     rs1_val, rs2_val;

  logic      op_valid_q, op_valid_d;
  data_t     op_a_q, op_a_d, op_b_q, op_b_d;
  reg_addr_t op_dst_q, op_dst_d;
  logic      op_dst_en_q, op_dst_en_d;
  logic      wb_spurious_q, wb_spurious_d;

  always_comb begin
    q_addr[0] = bus.id_rs1;
    q_addr[1] = bus.id_rs2;
    q_addr[2] = bus.id_dst;
  end

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (accept && bus.id_dst_en),
    .set_addr  (bus.id_dst),
    .clr_en    (bus.wb_valid),
    .clr_addr  (bus.wb_addr),
    .q_addr    (q_addr),
    .q_blocked (blk),
    .busy      (busy)
  );

  assign hazard       = blk[0] | (bus.id_use_rs2 & blk[1]) | (bus.id_dst_en & blk[2]);
  assign bus.id_ready = (!op_valid_q | bus.op_ready) & !hazard;
  assign accept       = bus.id_valid & bus.id_ready;

  // Same-cycle writeback is forwarded so a source released this cycle reads the new value.
  always_comb begin
    rs1_val = (bus.wb_valid && bus.wb_addr == bus.id_rs1) ? bus.wb_data : regs_q[bus.id_rs1];
    rs2_val = (bus.wb_valid && bus.wb_addr == bus.id_rs2) ? bus.wb_data : regs_q[bus.id_rs2];
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.wb_valid) regs_d[bus.wb_addr] = bus.wb_data;
  end

  always_comb begin
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_dst_d    = op_dst_q;
    op_dst_en_d = op_dst_en_q;
    if (accept) begin
      op_valid_d  = 1'b1;
      op_a_d      = rs1_val;
      op_b_d      = bus.id_use_rs2 ? rs2_val : '0;
      op_dst_d    = bus.id_dst;
      op_dst_en_d = bus.id_dst_en;
    end else if (bus.op_ready) begin
      op_valid_d  = 1'b0;
    end
    wb_spurious_d = bus.wb_valid & !busy[bus.wb_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      op_valid_q    <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_dst_q      <= '0;
      op_dst_en_q   <= 1'b0;
      wb_spurious_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      op_valid_q    <= op_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_dst_q      <= op_dst_d;
      op_dst_en_q   <= op_dst_en_d;
      wb_spurious_q <= wb_spurious_d;
    end
  end

  assign bus.op_valid  = op_valid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_dst    = op_dst_q;
  assign bus.op_dst_en = op_dst_en_q;
  assign wb_spurious   = wb_spurious_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a reference model and an expected-bundle queue.
module tb_operand_fetch;
  import coa_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREG-1:0] busy;
  logic wb_spurious;

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .busy        (busy),
    .wb_spurious (wb_spurious)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    data_t     a;
    data_t     b;
    reg_addr_t dst;
    logic      dst_en;
  } bundle_t;

  bundle_t         exp_q[$];
  data_t           regs_m [NREG];
  logic [NREG-1:0] busy_m;
  logic            spur_m;
  logic            opv_m;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic data_t val_m(reg_addr_t x);
    return (ifc.wb_valid && ifc.wb_addr == x) ? ifc.wb_data : regs_m[x];
  endfunction

  function automatic logic blocked_m(reg_addr_t x);
    return busy_m[x] && !(ifc.wb_valid && ifc.wb_addr == x);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    busy_m = '0;
    spur_m = 1'b0;
    opv_m  = 1'b0;
    exp_q.delete();
  endtask

  // One clock: called right after a falling edge with inputs already driven.
  task automatic cycle();
    logic    hz, rdy_m, acc;
    bundle_t e;
    #1;
    hz    = blocked_m(ifc.id_rs1) | (ifc.id_use_rs2 & blocked_m(ifc.id_rs2)) |
            (ifc.id_dst_en & blocked_m(ifc.id_dst));
    rdy_m = (!opv_m | ifc.op_ready) & !hz;
    check("id_ready", ifc.id_ready, rdy_m);
    acc = ifc.id_valid & rdy_m;
    if (ifc.op_valid && ifc.op_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL pop_empty: observed op_valid=1 expected no pending bundle");
      end else begin
        e = exp_q.pop_front();
        check("op_a", ifc.op_a, e.a);
        check("op_b", ifc.op_b, e.b);
        check("op_dst", ifc.op_dst, e.dst);
        check("op_dst_en", ifc.op_dst_en, e.dst_en);
      end
    end
    if (acc) begin
      e.a      = val_m(ifc.id_rs1);
      e.b      = ifc.id_use_rs2 ? val_m(ifc.id_rs2) : '0;
      e.dst    = ifc.id_dst;
      e.dst_en = ifc.id_dst_en;
      exp_q.push_back(e);
    end
    spur_m = ifc.wb_valid & !busy_m[ifc.wb_addr];
    if (ifc.wb_valid) begin
      regs_m[ifc.wb_addr] = ifc.wb_data;
      busy_m[ifc.wb_addr] = 1'b0;
    end
    if (acc && ifc.id_dst_en) busy_m[ifc.id_dst] = 1'b1;
    if (acc) opv_m = 1'b1;
    else if (ifc.op_ready) opv_m = 1'b0;
    @(posedge clk);
    #1;
    check("busy", busy, busy_m);
    check("wb_spurious", wb_spurious, spur_m);
    check("op_valid", ifc.op_valid, opv_m);
    $display("t=%0t v=%0b rs1=%0d rs2=%0d u2=%0b dst=%0d de=%0b ordy=%0b wb=%0b/%0d/%02h acc=%0b busy=%b opv=%0b a=%02h b=%02h",
             $time, ifc.id_valid, ifc.id_rs1, ifc.id_rs2, ifc.id_use_rs2, ifc.id_dst, ifc.id_dst_en,
             ifc.op_ready, ifc.wb_valid, ifc.wb_addr, ifc.wb_data, acc, busy, ifc.op_valid,
             ifc.op_a, ifc.op_b);
    @(negedge clk);
  endtask

  task automatic drive(logic v, reg_addr_t r1, reg_addr_t r2, logic u2, reg_addr_t d, logic de,
                       logic ordy, logic wv, reg_addr_t wa, data_t wd);
    ifc.id_valid   = v;
    ifc.id_rs1     = r1;
    ifc.id_rs2     = r2;
    ifc.id_use_rs2 = u2;
    ifc.id_dst     = d;
    ifc.id_dst_en  = de;
    ifc.op_ready   = ordy;
    ifc.wb_valid   = wv;
    ifc.wb_addr    = wa;
    ifc.wb_data    = wd;
  endtask

  task automatic step(logic v, reg_addr_t r1, reg_addr_t r2, logic u2, reg_addr_t d, logic de,
                      logic ordy, logic wv, reg_addr_t wa, data_t wd);
    drive(v, r1, r2, u2, d, de, ordy, wv, wa, wd);
    cycle();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    model_reset();
    #12;
    check("rst_op_valid", ifc.op_valid, 1'b0);
    check("rst_busy", busy, '0);
    check("rst_op_a", ifc.op_a, '0);
    check("rst_spurious", wb_spurious, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: write r2, read it back with rs2=r0
    step(0, 0, 0, 0, 0, 0, 1, 1, 2, 8'h5A);
    step(1, 2, 0, 1, 0, 0, 1, 0, 0, 8'h00);
    idle();

    // 2: RAW stall on r1, released by same-cycle writeback with bypass
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 0, 1, 1, 1, 8'h33);
    idle();

    // 3: execute backpressure holds the bundle, then the next one loads
    step(1, 2, 1, 1, 0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 2, 1, 2, 0, 0, 0, 0, 8'h00);
    step(1, 0, 2, 1, 2, 0, 1, 0, 0, 8'h00);
    idle();

    // 4: WAW on r3; retire and re-claim in the same cycle keeps busy[3] set
    step(1, 0, 0, 0, 3, 1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 3, 1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 3, 1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 3, 1, 1, 1, 3, 8'h77);
    idle();

    // 5: writeback to a non-busy register still writes and flags spurious once
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h11);
    idle();
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
    idle();

    // 6: reset mid-stall with a held bundle and busy=1010
    step(1, 2, 0, 0, 1, 1, 1, 0, 0, 8'h00);
    check("pre_rst_busy", busy, 4'b1010);
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_op_valid", ifc.op_valid, 1'b0);
    check("async_busy", busy, '0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      step(1, reg_addr_t'(r), reg_addr_t'(r), 1, 0, 0, 1, 0, 0, 8'h00);
    end
    idle();
    idle();
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
